dbg_cmd_frontend: RTL and testbench
===================================

# dbg_cmd_frontend

Upstream conditioning stage between the board's push-buttons and slide switches and the CPU debug command port (`addr_in`, `data_in`, `cmd` of `CPU_top`). It synchronises and debounces four buttons and turns each clean press into exactly one command window. During that window it presents a frozen address/data snapshot taken from the switches. This replaces free-running switch sampling, so a command is issued once per press rather than every clock.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, default 1000000: consecutive stable cycles required to accept a button level change (10 ms at 100 MHz).
- `CMD_HOLD`, default 4: cycles a non-NOP `cmd` is held.

Ports:
- `clk` in 1: single system clock.
- `reset` in 1: synchronous, active-high.
- `btnU`, `btnD`, `btnR`, `btnL` in 1 each: raw, asynchronous, bouncing buttons.
- `sw` in 16: raw switches. `[7:0]` base address, `[13:8]` write data, `[15:14]` unused.
- `addr_in` out 32: `{24'b0, sw[7:0] + offset}`, 8-bit sum wrapping mod 256.
- `data_in` out 32: `{26'b0, sw[13:8]}`.
- `cmd` out 2: 00 NOP, 01 WRITE, 10 READ, 11 STEP.
- `busy` out 1: high whenever FSM is not IDLE.
- `offset` out 8: current address offset, intended for LED display.

## Operation
- **Input conditioning:** each button passes through a 2-FF synchroniser, then a debouncer.
  - The debounced level flips only after the synchronised input has differed from it for `DEBOUNCE_CYCLES` consecutive cycles.
  - Any agreeing sample clears the counter.
  - A one-cycle `press` pulse is generated on a debounced 0→1 transition. Release produces no pulse.
- **Button mapping:**
  - btnU → WRITE.
  - btnD → READ.
  - btnR → STEP.
  - btnL → no command; `offset <= offset + 1` (wraps 255→0) and FSM goes to WAIT_REL.
- **Simultaneous presses** in the same cycle: priority U > D > R > L. Only the winner acts; losers are discarded.
- **FSM states:**
  - IDLE: `cmd` = 00. On a press pulse: latch the snapshot `addr_in`, `data_in` from the current synchronised `sw` plus `offset`, load the hold counter with `CMD_HOLD-1`, and go to ISSUE. btnL instead goes directly to WAIT_REL.
  - ISSUE: `cmd` = latched code. `addr_in`/`data_in` are frozen. Counter decrements each cycle. At 0, go to WAIT_REL.
  - WAIT_REL: `cmd` = 00. Return to IDLE when all four debounced levels are 0.
- Press pulses arriving outside IDLE are ignored. They are not queued.
- Switches are sampled only at the IDLE→ISSUE transition. Switch changes during ISSUE have no effect.
- `addr_in`/`data_in` keep the last snapshot after ISSUE ends.
- **Reset values:**
  - `cmd` = 00, `busy` = 0, `offset` = 0, `addr_in` = 0, `data_in` = 0.
  - FSM = IDLE; debounced levels = 0; all counters = 0.

## Timing
- All outputs are registered. Nothing combinational runs from input to output.
- Press latency: a clean level change on `btnX`, first sampled at edge 0, gives `press` at edge `DEBOUNCE_CYCLES+2`. `cmd` becomes valid at edge `DEBOUNCE_CYCLES+3`.
- `cmd` is non-zero for exactly `CMD_HOLD` consecutive cycles, then 00 for at least 1 cycle before any next command.
- `busy` rises in the same cycle `cmd` becomes non-zero, or the cycle after a btnL press. It falls the cycle after all buttons are debounced-released.
- A bounce shorter than `DEBOUNCE_CYCLES` produces no pulse and no command.
- Holding a button produces one command only. Re-issue requires release followed by a new press.
- Reset asserted mid-ISSUE: `cmd` = 00 and FSM = IDLE at the next edge.
  - A button still held through reset deassertion gives a new press only after it has been debounced high from the reset-cleared state, i.e. `DEBOUNCE_CYCLES` after reset falls.

## Structure
- Shared package `dbg_cmd_pkg`:
  - `cmd` encodings `CMD_NOP`/`CMD_WRITE`/`CMD_READ`/`CMD_STEP`.
  - FSM state encoding IDLE/ISSUE/WAIT_REL.
- Sub-module `btn_debounce`, parameterised by `DEBOUNCE_CYCLES`:
  - Ports: `clk`, `reset`, `btn_raw` → `level`, `press`.
  - Contains the synchroniser, counter and edge detector; instantiated four times.
- The top contains the priority encoder, FSM, hold counter, offset register and snapshot registers.

## Test plan
All scenarios use `DEBOUNCE_CYCLES`=4, `CMD_HOLD`=2.
- sw=16'h2A05, btnU held high from cycle 0 → `cmd`=01 at edges 7–8, `addr_in`=32'h05, `data_in`=32'h2A; `cmd`=00 at edge 9; `busy` stays high until btnU is released and debounced.
- btnD toggled 1,0,1,0 at 1-cycle spacing then held low → `cmd` stays 00 and `busy` stays 0 throughout.
- btnL pressed and released 3 times, then btnD with sw[7:0]=8'hFE → READ issued with `addr_in`=32'h01 (wrap), `offset`=3.
- btnU and btnR rise in the same cycle → single WRITE (01) for 2 cycles; no STEP issued, even after btnU releases while btnR is still held.
- `reset` pulsed for 1 cycle at the first ISSUE cycle of a STEP → `cmd`=00 and `busy`=0 at the next edge, `offset`=0; the still-held button reissues STEP 4+3 cycles after reset falls.
- sw changed from 16'h0011 to 16'h0022 during ISSUE of a WRITE → `addr_in` remains 32'h11 for the whole window.

Source files
------------

// File: rtl/dbg_cmd_pkg.sv
// Shared encodings for the debug command front end: command codes,
// FSM states and button indices.
package dbg_cmd_pkg;

  typedef enum logic [1:0] {
    CMD_NOP   = 2'b00,
    CMD_WRITE = 2'b01,
    CMD_READ  = 2'b10,
    CMD_STEP  = 2'b11
  } cmd_e;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'b00,
    ST_ISSUE    = 2'b01,
    ST_WAIT_REL = 2'b10
  } state_e;

  localparam int unsigned NUM_BTN = 4;
  localparam int unsigned BTN_U   = 0;
  localparam int unsigned BTN_D   = 1;
  localparam int unsigned BTN_R   = 2;
  localparam int unsigned BTN_L   = 3;

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchroniser, consecutive-sample debouncer and rising-edge
// detector for a single raw push-button.
module btn_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_raw,
  output logic level,
  output logic press
);

  localparam int unsigned CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  logic          sync1_q, sync2_q;
  logic          level_q, level_d;
  logic          prev_q;
  logic          press_q;
  logic [CW-1:0] cnt_q, cnt_d;

  // Level flips on the DEBOUNCE_CYCLES-th consecutive disagreeing sample.
  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    if (sync2_q != level_q) begin
      if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
        level_d = sync2_q;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      cnt_q   <= '0;
      prev_q  <= 1'b0;
      press_q <= 1'b0;
    end else begin
      sync1_q <= btn_raw;
      sync2_q <= sync1_q;
      level_q <= level_d;
      cnt_q   <= cnt_d;
      prev_q  <= level_q;
      press_q <= level_q & ~prev_q;
    end
  end

  assign level = level_q;
  assign press = press_q;

endmodule

// File: rtl/dbg_cmd_frontend.sv
// Turns debounced button presses into single, fixed-length debug command
// windows with a frozen switch-derived address/data snapshot.
module dbg_cmd_frontend #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned CMD_HOLD        = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        btnU,
  input  logic        btnD,
  input  logic        btnR,
  input  logic        btnL,
  input  logic [15:0] sw,
  output logic [31:0] addr_in,
  output logic [31:0] data_in,
  output logic [1:0]  cmd,
  output logic        busy,
  output logic [7:0]  offset
);

  import dbg_cmd_pkg::*;

  localparam int unsigned HW = (CMD_HOLD > 1) ? $clog2(CMD_HOLD) : 1;

  logic [NUM_BTN-1:0] btn_raw;
  logic [NUM_BTN-1:0] level;
  logic [NUM_BTN-1:0] press;

  assign btn_raw = {btnL, btnR, btnD, btnU};

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
    btn_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_btn (
      .clk    (clk),
      .reset  (reset),
      .btn_raw(btn_raw[i]),
      .level  (level[i]),
      .press  (press[i])
    );
  end

  logic [13:0] sw_s1_q, sw_s2_q;
  logic        unused_sw;
  assign unused_sw = ^sw[15:14];

  state_e        state_q, state_d;
  logic [HW-1:0] hold_q, hold_d;
  cmd_e          cmd_q, cmd_d;
  logic [7:0]    offset_q, offset_d;
  logic [7:0]    addr_q, addr_d;
  logic [5:0]    data_q, data_d;
  logic          busy_q;

  // Priority U > D > R > L; btnL only wins when no command button pressed.
  cmd_e win_cmd;
  logic win_l;
  always_comb begin
    win_cmd = CMD_NOP;
    win_l   = 1'b0;
    if (press[BTN_U])      win_cmd = CMD_WRITE;
    else if (press[BTN_D]) win_cmd = CMD_READ;
    else if (press[BTN_R]) win_cmd = CMD_STEP;
    else if (press[BTN_L]) win_l   = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sw_s1_q  <= '0;
      sw_s2_q  <= '0;
      state_q  <= ST_IDLE;
      hold_q   <= '0;
      cmd_q    <= CMD_NOP;
      offset_q <= '0;
      addr_q   <= '0;
      data_q   <= '0;
      busy_q   <= 1'b0;
    end else begin
      sw_s1_q  <= sw[13:0];
      sw_s2_q  <= sw_s1_q;
      state_q  <= state_d;
      hold_q   <= hold_d;
      cmd_q    <= cmd_d;
      offset_q <= offset_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      busy_q   <= (state_d != ST_IDLE);
    end
  end

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    case (state_q)
      ST_IDLE: begin
        if (win_cmd != CMD_NOP) begin
          state_d = ST_ISSUE;
          hold_d  = HW'(CMD_HOLD - 1);
        end else if (win_l) begin
          state_d = ST_WAIT_REL;
        end
      end
      ST_ISSUE: begin
        if (hold_q == '0) state_d = ST_WAIT_REL;
        else              hold_d  = hold_q - HW'(1);
      end
      ST_WAIT_REL: begin
        if (level == '0) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs are computed as next-state so every port comes straight from a flop.
  always_comb begin
    cmd_d    = cmd_q;
    offset_d = offset_q;
    addr_d   = addr_q;
    data_d   = data_q;
    case (state_q)
      ST_IDLE: begin
        cmd_d = CMD_NOP;
        if (win_cmd != CMD_NOP) begin
          cmd_d  = win_cmd;
          addr_d = sw_s2_q[7:0] + offset_q;
          data_d = sw_s2_q[13:8];
        end else if (win_l) begin
          offset_d = offset_q + 8'd1;
        end
      end
      ST_ISSUE: begin
        if (hold_q == '0) cmd_d = CMD_NOP;
      end
      default: cmd_d = CMD_NOP;
    endcase
  end

  assign addr_in = {24'b0, addr_q};
  assign data_in = {26'b0, data_q};
  assign cmd     = cmd_q;
  assign busy    = busy_q;
  assign offset  = offset_q;

endmodule

// File: tb/tb_dbg_cmd_frontend.sv
// Bench for dbg_cmd_frontend: directed scenarios plus randomized button and
// switch activity, checked every cycle against a behavioural model.
module tb_dbg_cmd_frontend;

  localparam int unsigned DB   = 4;
  localparam int unsigned HOLD = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        btnU, btnD, btnR, btnL;
  logic [15:0] sw;
  logic [31:0] addr_in, data_in;
  logic [1:0]  cmd;
  logic        busy;
  logic [7:0]  offset;

  always #5 clk = ~clk;

  dbg_cmd_frontend #(
    .DEBOUNCE_CYCLES(DB),
    .CMD_HOLD       (HOLD)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .btnU   (btnU),
    .btnD   (btnD),
    .btnR   (btnR),
    .btnL   (btnL),
    .sw     (sw),
    .addr_in(addr_in),
    .data_in(data_in),
    .cmd    (cmd),
    .busy   (busy),
    .offset (offset)
  );

  int nvec = 0;
  int nerr = 0;
  bit chk_en = 1'b0;

  // Model: raw-sample history per button, disagreement run lengths,
  // debounced levels, and a transaction view of the command window.
  bit [1:0]  m_hist [4];
  int        m_run  [4];
  bit [3:0]  m_lvl, m_rose, m_press;
  bit [15:0] m_swh  [2];
  int        m_mode;   // 0 idle, 1 command window, 2 waiting for release
  int        m_left;   // command cycles still to show
  bit [1:0]  m_cmd;
  bit [7:0]  m_off, m_addr;
  bit [5:0]  m_data;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    bit [3:0]  raw;
    bit [3:0]  old_press, old_lvl;
    bit [15:0] swsync;
    bit        sv;
    raw = {btnL, btnR, btnD, btnU};
    if (reset) begin
      for (int b = 0; b < 4; b++) begin
        m_hist[b] = '0;
        m_run[b]  = 0;
      end
      m_lvl = '0; m_rose = '0; m_press = '0;
      m_swh[0] = '0; m_swh[1] = '0;
      m_mode = 0; m_left = 0; m_cmd = '0;
      m_off = '0; m_addr = '0; m_data = '0;
      return;
    end
    old_press = m_press;
    old_lvl   = m_lvl;
    for (int b = 0; b < 4; b++) begin
      sv = m_hist[b][1];
      m_hist[b] = {m_hist[b][0], raw[b]};
      m_press[b] = m_rose[b];
      m_rose[b]  = 1'b0;
      if (sv != m_lvl[b]) begin
        m_run[b]++;
        if (m_run[b] == int'(DB)) begin
          m_lvl[b]  = sv;
          m_run[b]  = 0;
          m_rose[b] = sv;
        end
      end else begin
        m_run[b] = 0;
      end
    end
    swsync   = m_swh[1];
    m_swh[1] = m_swh[0];
    m_swh[0] = sw;
    case (m_mode)
      0: begin
        if (old_press[0] || old_press[1] || old_press[2]) begin
          m_cmd  = old_press[0] ? 2'b01 : (old_press[1] ? 2'b10 : 2'b11);
          m_addr = swsync[7:0] + m_off;
          m_data = swsync[13:8];
          m_left = HOLD;
          m_mode = 1;
        end else if (old_press[3]) begin
          m_off  = m_off + 8'd1;
          m_mode = 2;
        end
      end
      1: begin
        m_left--;
        if (m_left == 0) begin
          m_cmd  = 2'b00;
          m_mode = 2;
        end
      end
      default: if (old_lvl == 4'b0000) m_mode = 0;
    endcase
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("cmd",     {30'b0, cmd},    {30'b0, m_cmd});
      check("busy",    {31'b0, busy},   {31'b0, (m_mode != 0)});
      check("offset",  {24'b0, offset}, {24'b0, m_off});
      check("addr_in", addr_in,         {24'b0, m_addr});
      check("data_in", data_in,         {26'b0, m_data});
    end
  end

  task automatic step();
    model_step();
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic set_btn(input bit [3:0] m);
    {btnL, btnR, btnD, btnU} = m;
  endtask

  initial begin
    int cnt_w, cnt_s, lat;
    bit seen, chg;
    reset = 1'b1;
    sw    = '0;
    set_btn(4'b0000);
    chk_en = 1'b1;
    repeat (3) step();
    check("rst_cmd",    {30'b0, cmd},    32'h0);
    check("rst_busy",   {31'b0, busy},   32'h0);
    check("rst_offset", {24'b0, offset}, 32'h0);
    check("rst_addr",   addr_in,         32'h0);
    check("rst_data",   data_in,         32'h0);
    reset = 1'b0;

    // btnU held from edge 0: WRITE visible after edges 7 and 8
    sw = 16'h2A05;
    set_btn(4'b0001);
    for (int k = 1; k <= 14; k++) begin
      step();
      if (k == 8 || k == 9) begin
        check("s1_cmd",  {30'b0, cmd}, 32'h1);
        check("s1_addr", addr_in,      32'h05);
        check("s1_data", data_in,      32'h2A);
      end
      if (k == 10) check("s1_cmd_off", {30'b0, cmd}, 32'h0);
      if (k == 10 || k == 14) check("s1_busy_held", {31'b0, busy}, 32'h1);
    end
    set_btn(4'b0000);
    repeat (12) step();
    check("s1_busy_rel", {31'b0, busy}, 32'h0);

    // Bounce on btnD shorter than the debounce window
    for (int k = 0; k < 16; k++) begin
      set_btn((k < 4 && (k % 2 == 0)) ? 4'b0010 : 4'b0000);
      step();
      check("bounce_cmd",  {30'b0, cmd},  32'h0);
      check("bounce_busy", {31'b0, busy}, 32'h0);
    end

    // Three btnL presses, then READ with wrapping address
    for (int i = 0; i < 3; i++) begin
      set_btn(4'b1000);
      repeat (9) step();
      set_btn(4'b0000);
      repeat (9) step();
      check("l_offset", {24'b0, offset}, i + 1);
    end
    sw = 16'h00FE;
    repeat (3) step();
    set_btn(4'b0010);
    seen = 1'b0;
    for (int k = 0; k < 12; k++) begin
      step();
      if (cmd == 2'b10 && !seen) begin
        seen = 1'b1;
        check("wrap_addr",   addr_in,         32'h01);
        check("wrap_offset", {24'b0, offset}, 32'h03);
      end
    end
    check("wrap_seen", {31'b0, seen}, 32'h1);
    set_btn(4'b0000);
    repeat (12) step();

    // btnU and btnR together: one WRITE, never a STEP
    cnt_w = 0; cnt_s = 0;
    for (int k = 0; k < 40; k++) begin
      set_btn(k < 14 ? 4'b0101 : (k < 28 ? 4'b0100 : 4'b0000));
      step();
      if (cmd == 2'b01) cnt_w++;
      if (cmd == 2'b11) cnt_s++;
    end
    check("ur_write_cycles", cnt_w, 2);
    check("ur_step_cycles",  cnt_s, 0);

    // Reset in the first STEP cycle; held btnR reissues afterwards
    set_btn(4'b0100);
    seen = 1'b0;
    for (int k = 0; k < 12; k++) begin
      if (!seen) begin
        step();
        if (cmd == 2'b11) seen = 1'b1;
      end
    end
    check("step_seen", {31'b0, seen}, 32'h1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("mid_rst_cmd",    {30'b0, cmd},    32'h0);
    check("mid_rst_busy",   {31'b0, busy},   32'h0);
    check("mid_rst_offset", {24'b0, offset}, 32'h0);
    lat = 0;
    for (int j = 1; j <= 12; j++) begin
      step();
      if (cmd == 2'b11 && lat == 0) lat = j;
    end
    check("reissue_latency", lat, 8);
    set_btn(4'b0000);
    repeat (12) step();

    // Switch change during the WRITE window is ignored
    sw = 16'h0011;
    repeat (3) step();
    set_btn(4'b0001);
    chg = 1'b0;
    for (int k = 0; k < 14; k++) begin
      step();
      if (cmd == 2'b01) begin
        if (!chg) begin
          sw  = 16'h0022;
          chg = 1'b1;
        end
        check("frozen_addr", addr_in, 32'h11);
      end
    end
    check("frozen_seen", {31'b0, chg}, 32'h1);
    set_btn(4'b0000);
    repeat (12) step();

    // Randomized activity
    for (int seg = 0; seg < 250; seg++) begin
      int unsigned r, dur;
      r = $urandom_range(0, 7);
      if (r < 3)      set_btn(4'b0000);
      else if (r < 6) set_btn(4'(1 << $urandom_range(0, 3)));
      else            set_btn(4'($urandom_range(0, 15)));
      if ($urandom_range(0, 3) == 0) sw = 16'($urandom);
      reset = ($urandom_range(0, 39) == 0);
      dur = $urandom_range(1, 12);
      for (int unsigned d = 0; d < dur; d++) begin
        step();
        reset = 1'b0;
      end
    end
    set_btn(4'b0000);
    repeat (12) step();

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
